// File: rtl/usb_rx_block_ctrl.sv
// Drains the usb_receiver byte FIFO into fixed-size, padded blocks on a valid/ready port.
// Optional stall timeout in FILL is built only when USB_RX_CTRL_TIMEOUT_EN is defined.
module usb_rx_block_ctrl #(
   parameter int          BLOCK_BYTES    = 16,
   parameter logic [7:0]  PAD_BYTE       = 8'h00,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [7:0]                           rx_r_data,
   input  logic                                 rx_empty,
   input  logic                                 rx_full,
   input  logic                                 rx_rcving,
   input  logic                                 rx_r_error,
   output logic                                 rx_r_enable,
   output logic [8*BLOCK_BYTES-1:0]             blk_data,
   output logic [$clog2(BLOCK_BYTES+1)-1:0]     blk_len,
   output logic                                 blk_last,
   output logic                                 blk_valid,
   input  logic                                 blk_ready,
   output logic                                 pkt_drop,
   output logic                                 overflow,
   output logic                                 busy
);

   localparam int            CW       = $clog2(BLOCK_BYTES + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(BLOCK_BYTES);
   localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [CW-1:0]   byte_cnt_r;
   logic            sent_partial_r;
   logic            err_seen_r;
   logic            pop_s;
   logic            full_s;
   logic            pad_s;
   logic            drop_s;
   logic            fill_s;
   logic            new_pkt_s;
   logic            end_cond_s;
   logic            timeout_hit_s;

   assign end_cond_s = !rx_rcving && rx_empty;

`ifdef USB_RX_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] stall_cnt_r;

   // Stall counter: restarts on every pop and on FILL entry, counts idle packet time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {TW{1'b0}};
      end else if (fill_s || pop_s) begin
         stall_cnt_r <= {TW{1'b0}};
      end else if ((state_r == ST_FILL) && rx_rcving && rx_empty) begin
         stall_cnt_r <= stall_cnt_r + TW'(1);
      end
   end

   assign timeout_hit_s = (state_r == ST_FILL) && rx_rcving && rx_empty &&
                          (stall_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
   // Without the timeout FILL waits indefinitely; this term is constant false.
   assign timeout_hit_s = (TIMEOUT_CYCLES < 0);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and the one-cycle datapath strobes that go with each transition.
   always_comb begin
      next_state_s = state_r;
      pop_s        = 1'b0;
      full_s       = 1'b0;
      pad_s        = 1'b0;
      drop_s       = 1'b0;
      fill_s       = 1'b0;
      new_pkt_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rx_rcving || !rx_empty) begin
               next_state_s = ST_FILL;
               fill_s       = 1'b1;
               new_pkt_s    = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            // An error outranks a pop that would complete the block.
            if (rx_r_error) begin
               next_state_s = ST_DROP;
               drop_s       = 1'b1;
            end else if (!rx_empty) begin
               pop_s = 1'b1;
               if (byte_cnt_r == LAST_IDX) begin
                  next_state_s = ST_PRESENT;
                  full_s       = 1'b1;
               end else begin
                  next_state_s = ST_FILL;
               end
            end else if (end_cond_s) begin
               if ((byte_cnt_r != {CW{1'b0}}) || sent_partial_r) begin
                  next_state_s = ST_PRESENT;
                  pad_s        = 1'b1;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else if (timeout_hit_s) begin
               next_state_s = ST_DROP;
               drop_s       = 1'b1;
            end else begin
               next_state_s = ST_FILL;
            end
         end
         ST_PRESENT: begin
            if (blk_ready) begin
               if (err_seen_r || rx_r_error) begin
                  next_state_s = ST_DROP;
                  drop_s       = 1'b1;
               end else if (blk_last) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_FILL;
                  fill_s       = 1'b1;
               end
            end else begin
               next_state_s = ST_PRESENT;
            end
         end
         ST_DROP: begin
            if (rx_empty && !rx_rcving && !rx_r_error) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DROP;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // FIFO pop strobe: combinational so a byte is taken on the same edge it is seen.
   always_comb begin
      rx_r_enable = 1'b0;
      case (state_r)
         ST_FILL: rx_r_enable = !rx_empty && !rx_r_error;
         ST_DROP: rx_r_enable = !rx_empty;
         default: rx_r_enable = 1'b0;
      endcase
   end

   // Block assembly: lane writes, padding, length/last capture and packet bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_r     <= {CW{1'b0}};
         blk_data       <= {(8*BLOCK_BYTES){1'b0}};
         blk_len        <= {CW{1'b0}};
         blk_last       <= 1'b0;
         sent_partial_r <= 1'b0;
      end else begin
         if (fill_s) begin
            byte_cnt_r <= {CW{1'b0}};
         end else if (pop_s) begin
            byte_cnt_r <= byte_cnt_r + CW'(1);
         end
         for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (pop_s && (byte_cnt_r == CW'(k))) begin
               blk_data[8*k +: 8] <= rx_r_data;
            end else if (pad_s && (byte_cnt_r <= CW'(k))) begin
               blk_data[8*k +: 8] <= PAD_BYTE;
            end
         end
         if (full_s) begin
            blk_len  <= FULL_CNT;
            blk_last <= 1'b0;
         end else if (pad_s) begin
            blk_len  <= byte_cnt_r;
            blk_last <= 1'b1;
         end
         if (new_pkt_s) begin
            sent_partial_r <= 1'b0;
         end else if (full_s) begin
            sent_partial_r <= 1'b1;
         end
      end
   end

   // Status outputs and the error flag remembered while a block is on display.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_valid  <= 1'b0;
         busy       <= 1'b0;
         pkt_drop   <= 1'b0;
         overflow   <= 1'b0;
         err_seen_r <= 1'b0;
      end else begin
         blk_valid <= (next_state_s == ST_PRESENT);
         busy      <= (next_state_s != ST_IDLE);
         pkt_drop  <= drop_s;
         if (rx_full && ((state_r == ST_FILL) || (state_r == ST_PRESENT))) begin
            overflow <= 1'b1;
         end
         if (next_state_s != ST_PRESENT) begin
            err_seen_r <= 1'b0;
         end else if ((state_r == ST_PRESENT) && rx_r_error) begin
            err_seen_r <= 1'b1;
         end
      end
   end

endmodule

// File: doc/usb_rx_block_ctrl.md
Name: usb_rx_block_ctrl

Overview:
- Controller that drains the usb_receiver byte FIFO and packs received packet bytes into fixed-size blocks for the downstream encryptor core.
- Sequences the receiver's r_enable pops and tracks packet boundaries using rcving, empty and r_error.
- Presents each block on a valid/ready interface, pads the final partial block of a packet, and discards any packet that errored.

Parameters:
- BLOCK_BYTES, 16, bytes per output block (2..32).
- PAD_BYTE, 8'h00, fill value for unused lanes of a final partial block.
- TIMEOUT_CYCLES, 1024, stall limit in cycles; used only with USB_RX_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_r_data  in  8  receiver FIFO head byte; valid when rx_empty=0 (show-ahead).
- rx_empty  in  1  receiver FIFO empty.
- rx_full  in  1  receiver FIFO full.
- rx_rcving  in  1  receiver is inside a packet.
- rx_r_error  in  1  receiver packet error.
- rx_r_enable  out  1  pops one FIFO byte at the next clk edge.
- blk_data  out  8*BLOCK_BYTES  block; byte k occupies bits [8k+7:8k], first-received byte in lane 0.
- blk_len  out  $clog2(BLOCK_BYTES+1)  number of valid bytes in blk_data.
- blk_last  out  1  this block ends the packet.
- blk_valid  out  1  block available.
- blk_ready  in  1  downstream accepts block.
- pkt_drop  out  1  one-cycle pulse: current packet discarded.
- overflow  out  1  sticky: rx_full seen while a packet was active; cleared only by rst.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; byte_cnt=0; blk_data=0, blk_len=0, blk_last=0, blk_valid=0, pkt_drop=0, overflow=0, rx_r_enable=0.
- States: IDLE, FILL, PRESENT, DROP.
- IDLE → FILL when rx_rcving=1 or rx_empty=0. Entering FILL clears byte_cnt.
- FILL:
  - rx_r_enable = !rx_empty && !rx_r_error. This is combinational and pops at most one byte per cycle.
  - On each pop, rx_r_data is written into lane byte_cnt at the same edge, then byte_cnt increments.
- Packet end in FILL: end_cond = !rx_rcving && rx_empty (all bytes drained).
- FILL → PRESENT with blk_last=0, blk_len=BLOCK_BYTES when a pop makes byte_cnt reach BLOCK_BYTES.
- FILL → PRESENT on end_cond with byte_cnt>0:
  - Lanes byte_cnt..BLOCK_BYTES-1 are set to PAD_BYTE.
  - blk_len=byte_cnt, blk_last=1.
- FILL on end_cond with byte_cnt=0:
  - If a prior block of this packet was sent with blk_last=0, emit a zero-length terminator: blk_len=0, blk_last=1, all lanes PAD_BYTE.
  - Otherwise (empty packet) return to IDLE with no output.
- PRESENT:
  - blk_valid=1. blk_data, blk_len and blk_last are held stable until blk_valid && blk_ready.
  - No pops occur in PRESENT.
  - On handshake: if blk_last=1 go to IDLE, else go to FILL with byte_cnt=0.
- Latency: the block is valid on the cycle after the edge that captured its final byte (or the edge that detected end_cond).
- Error, rx_r_error=1 in FILL: go to DROP, discard accumulated bytes, pulse pkt_drop for 1 cycle.
- Error, rx_r_error=1 in PRESENT: the presented block is not retracted. Record the error, complete the handshake, then go to DROP. The pkt_drop pulse occurs on DROP entry.
- DROP: rx_r_enable = !rx_empty. Bytes are popped and discarded. Go to IDLE when rx_empty=1, rx_rcving=0 and rx_r_error=0.
- overflow is set on any cycle with rx_full=1 while state is FILL or PRESENT.
- Simultaneous events:
  - Error and full block in the same cycle: the error wins; the block is not presented.
  - end_cond and the pop filling the block in the same cycle: block presented with blk_last=0; the terminator block follows.

Optional Feature:
- Macro: USB_RX_CTRL_TIMEOUT_EN.
- When defined: a stall counter runs in FILL.
  - It clears on every pop and on entry to FILL, and increments while rx_rcving=1 && rx_empty=1.
  - When it reaches TIMEOUT_CYCLES, the controller goes to DROP and pulses pkt_drop.
- When undefined: no counter is built, TIMEOUT_CYCLES is ignored, and FILL waits indefinitely.

Test Plan:
- Reset mid-FILL, with 5 bytes captured → all outputs 0 and state IDLE immediately, without waiting for a clk edge.
- 3-byte packet 8'h0B,8'h2C,8'h71 then EOP, BLOCK_BYTES=16 → one block: lanes 0..2=0B,2C,71; lanes 3..15=00; blk_len=3, blk_last=1.
- 16-byte packet 00..0F, blk_ready held low 10 cycles → blk_data stable with blk_len=16, blk_last=0; no pops while held. After the handshake, a zero-length terminator follows (blk_len=0, blk_last=1).
- 20-byte packet → block 1: 16 bytes, last=0; block 2: blk_len=4, lanes 4..15=PAD_BYTE, last=1.
- rx_r_error asserted after 6 bytes → pkt_drop single pulse, no block presented, FIFO drained until rx_empty=1, then IDLE. The next good packet 8'h18 yields blk_len=1.
- rx_full=1 for 1 cycle during FILL → overflow=1 and stays 1 until rst. With USB_RX_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8: rcving high, no data for 8 cycles → pkt_drop pulse, then DROP.
